// File: rtl/idea_pkg.sv
// Purpose: shared constants, FSM state enum and decryption-key mapping table for the IDEA key scheduler.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package idea_pkg;

  localparam int SK_W = 16;     // subkey width
  localparam int N_SK = 52;     // 8 rounds x 6 + 4 output-transform keys
  localparam int ROT  = 25;     // key rotation between 8-subkey groups
  localparam int MOD  = 65537;  // multiplicative group modulus

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STEP,
    ST_INV,
    ST_DONE
  } dk_state_e;

  typedef enum logic [1:0] {
    OP_PASS,
    OP_ADDINV,
    OP_MULINV
  } dk_op_e;

  typedef struct packed {
    logic [5:0] src;  // encryption subkey index Z[src]
    dk_op_e     op;   // transform applied to Z[src]
  } dk_map_t;

  // Source subkey and transform for decryption subkey DK[idx].
  // Group r (6 keys each) draws from encryption group b = 6*(8-r). The two
  // additive keys swap places in the middle rounds only: the first and the
  // output-transform groups face an unswapped half-round.
  function automatic dk_map_t dk_map(input logic [5:0] idx);
    int      r;
    int      k;
    int      b;
    logic    edge_grp;
    dk_map_t m;
    r        = int'(idx) / 6;
    k        = int'(idx) % 6;
    b        = 6 * (8 - r);
    edge_grp = (r == 0) || (r == 8);
    m.op     = OP_PASS;
    m.src    = 6'(b);
    case (k)
      0: begin m.op = OP_MULINV; m.src = 6'(b); end
      1: begin m.op = OP_ADDINV; m.src = edge_grp ? 6'(b + 1) : 6'(b + 2); end
      2: begin m.op = OP_ADDINV; m.src = edge_grp ? 6'(b + 2) : 6'(b + 1); end
      3: begin m.op = OP_MULINV; m.src = 6'(b + 3); end
      4: begin m.op = OP_PASS;   m.src = 6'(b - 2); end
      default: begin m.op = OP_PASS; m.src = 6'(b - 1); end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/idea_mul_mod.sv
// Purpose: IDEA multiply mod 65537 with the 16-bit encoding 0 == 65536. Ports: a, b operands; p product.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of the inputs).
module idea_mul_mod
  import idea_pkg::*;
(
  input  logic [SK_W-1:0] a,
  input  logic [SK_W-1:0] b,
  output logic [SK_W-1:0] p
);

  logic [16:0] a_ext;
  logic [16:0] b_ext;
  logic [33:0] prod;
  logic [17:0] lo;
  logic [17:0] hi;
  logic [17:0] diff;

  // 2^16 == -1 (mod 65537), so prod = hi*2^16 + lo reduces to lo - hi. With
  // lo < 2^16 and hi <= 2^16 the difference needs at most one +MOD fix-up.
  // The result is never 0 (65537 is prime), and 65536 truncates to the
  // 0 encoding.
  always_comb begin
    a_ext = (a == '0) ? 17'h10000 : {1'b0, a};
    b_ext = (b == '0) ? 17'h10000 : {1'b0, b};
    prod  = {17'b0, a_ext} * {17'b0, b_ext};
    lo    = {2'b0, prod[15:0]};
    hi    = prod[33:16];
    diff  = lo - hi;
    if (diff[17]) begin
      diff = diff + 18'(MOD);
    end
    p = diff[SK_W-1:0];
  end

endmodule

// File: rtl/idea_dec_key_sched.sv
// Purpose: expands a 128-bit IDEA key and builds the 52 decryption subkeys one entry at a time.
//   Ports: start/key request; busy while generating; done 1-cycle pulse; dk flat bus (DK0 in MSBs), qualified by dk_valid.
// Latency: 323 cycles from the accepting edge to done; start is ignored (not queued) unless idle.
module idea_dec_key_sched
  import idea_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [127:0]           key,
  output logic                   busy,
  output logic                   done,
  output logic                   dk_valid,
  output logic [N_SK*SK_W-1:0]   dk
);

  dk_state_e       state_q, state_d;
  logic [127:0]    key_q, key_d;
  logic [SK_W-1:0] z_q  [N_SK];
  logic [SK_W-1:0] z_d  [N_SK];
  logic [SK_W-1:0] z_exp[N_SK];
  logic [SK_W-1:0] dk_q [N_SK];
  logic [SK_W-1:0] dk_d [N_SK];
  logic [5:0]      idx_q, idx_d;
  logic [3:0]      it_q, it_d;
  logic [SK_W-1:0] r_q, r_d;
  logic [SK_W-1:0] a_q, a_d;
  logic            dk_valid_q, dk_valid_d;

  dk_map_t         map;
  logic [SK_W-1:0] src;
  logic [SK_W-1:0] mr_a, mr_b, mr_p, ma_p;
  logic [127:0]    kr;

  always_comb begin
    map = dk_map(idx_q);
    src = z_q[map.src];
  end

  // x^65535 by square-and-multiply over all 16 exponent bits. The STEP cycle
  // already runs iteration 0 (r = 1*x, a = x*x), so INV needs 15 more cycles
  // and each multiplicative entry costs 16 cycles in total.
  assign mr_a = (state_q == ST_STEP) ? SK_W'(1) : r_q;
  assign mr_b = (state_q == ST_STEP) ? src      : a_q;

  idea_mul_mod u_mul_r (.a(mr_a), .b(mr_b), .p(mr_p));
  idea_mul_mod u_mul_a (.a(mr_b), .b(mr_b), .p(ma_p));

  // Encryption subkey expansion: 8 subkeys per 128-bit window, window rotated
  // left by ROT between groups.
  always_comb begin
    kr = key_q;
    for (int i = 0; i < N_SK; i++) begin
      if (i != 0 && (i % 8) == 0) begin
        kr = {kr[127-ROT:0], kr[127:128-ROT]};
      end
      z_exp[i] = kr[127 - SK_W*(i % 8) -: SK_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    z_d        = z_q;
    dk_d       = dk_q;
    idx_d      = idx_q;
    it_d       = it_q;
    r_d        = r_q;
    a_d        = a_q;
    dk_valid_d = dk_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d      = key;
          dk_valid_d = 1'b0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        z_d     = z_exp;
        idx_d   = '0;
        it_d    = '0;
        state_d = ST_STEP;
      end
      ST_STEP: begin
        if (map.op == OP_MULINV) begin
          r_d     = mr_p;
          a_d     = ma_p;
          it_d    = 4'd1;
          state_d = ST_INV;
        end else begin
          dk_d[idx_q] = (map.op == OP_ADDINV) ? (~src + SK_W'(1)) : src;
          if (idx_q == 6'(N_SK - 1)) begin
            dk_valid_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_INV: begin
        r_d  = mr_p;
        a_d  = ma_p;
        it_d = it_q + 4'd1;
        if (it_q == 4'd15) begin
          dk_d[idx_q] = mr_p;
          if (idx_q == 6'(N_SK - 1)) begin
            dk_valid_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = ST_STEP;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      z_q        <= '{default: '0};
      dk_q       <= '{default: '0};
      idx_q      <= '0;
      it_q       <= '0;
      r_q        <= '0;
      a_q        <= '0;
      dk_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      z_q        <= z_d;
      dk_q       <= dk_d;
      idx_q      <= idx_d;
      it_q       <= it_d;
      r_q        <= r_d;
      a_q        <= a_d;
      dk_valid_q <= dk_valid_d;
    end
  end

  assign busy     = (state_q == ST_LOAD) || (state_q == ST_STEP) || (state_q == ST_INV);
  assign done     = (state_q == ST_DONE);
  assign dk_valid = dk_valid_q;

  always_comb begin
    dk = '0;
    for (int i = 0; i < N_SK; i++) begin
      dk[N_SK*SK_W - 1 - SK_W*i -: SK_W] = dk_q[i];
    end
  end

endmodule
